// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential multiplier.
//   state_t      : controller state (IDLE, BUSY)
//   FUNC_LOAD_*  : function codes selecting the operand register written by a load
package seq_mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] FUNC_LOAD_M = 2'b00;
  localparam logic [1:0] FUNC_LOAD_Q = 2'b01;

endpackage

// File: rtl/edge_detect.sv
// One-bit rising-edge detector. The board top also uses this block.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high reset (clears the delayed copy)
//   in    : level input
//   out   : high for the cycle in which 'in' is high and was low on the previous edge
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic in_d;

  // Delayed copy, updated every cycle regardless of the consumer's state.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_d <= 1'b0;
    end else begin
      in_d <= in;
    end
  end

  assign out = in & ~in_d;

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-and-add multiplier with operand load registers and a
// start/ready handshake. Produces one product bit-step per clock (n steps).
// Build option: define BOOTH_EN for signed radix-2 Booth; otherwise unsigned.
// Ports:
//   clock   : system clock
//   reset   : synchronous, active-high reset
//   start   : debounced level; a rising edge requests a multiply
//   func    : load select (00 -> M, 01 -> Q, others ignored)
//   load    : write data_in to the selected register while idle
//   data_in : operand value
//   ready   : high when idle and AQ holds a result or the reset value
//   AQ      : {A,Q}; the product once ready is high
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       func,
  input  logic             load,
  input  logic [n-1:0]     data_in,
  output logic             ready,
  output logic [2*n-1:0]   AQ
);

  localparam int unsigned CW = $clog2(n + 1);

  state_t        state, state_nxt;
  logic [n-1:0]  m, m_nxt;
  logic [n-1:0]  q, q_nxt;
  logic [n-1:0]  a, a_nxt;
  logic          c, c_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ready_nxt;
  logic          go;
`ifdef BOOTH_EN
  logic          qm1, qm1_nxt;
  logic [n:0]    ext;
`else
  logic [n:0]    sum;
`endif

  // Start-edge detection; runs every cycle, including while busy.
  edge_detect u_start_edge (
    .clock (clock),
    .reset (reset),
    .in    (start),
    .out   (go)
  );

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_nxt = state;
    m_nxt     = m;
    q_nxt     = q;
    a_nxt     = a;
    c_nxt     = c;
    cnt_nxt   = cnt;
    ready_nxt = ready;
`ifdef BOOTH_EN
    qm1_nxt   = qm1;
    ext       = {a[n-1], a};
`else
    sum       = {c, a};
`endif
    case (state)
      IDLE: begin
        // A start edge takes priority; a coincident load is dropped.
        if (go) begin
          state_nxt = BUSY;
          a_nxt     = '0;
          c_nxt     = 1'b0;
          cnt_nxt   = CW'(n);
          ready_nxt = 1'b0;
`ifdef BOOTH_EN
          qm1_nxt   = 1'b0;
`endif
        end else if (load) begin
          if (func == FUNC_LOAD_M) begin
            m_nxt = data_in;
          end else if (func == FUNC_LOAD_Q) begin
            q_nxt = data_in;
          end
        end
      end
      BUSY: begin
`ifdef BOOTH_EN
        // Sign-extended to n+1 bits so A-M cannot overflow before the shift.
        case ({q[0], qm1})
          2'b10:   ext = {a[n-1], a} - {m[n-1], m};
          2'b01:   ext = {a[n-1], a} + {m[n-1], m};
          default: ext = {a[n-1], a};
        endcase
        a_nxt   = ext[n:1];
        q_nxt   = {ext[0], q[n-1:1]};
        qm1_nxt = q[0];
        c_nxt   = 1'b0;
`else
        if (q[0]) begin
          sum = {1'b0, a} + {1'b0, m};
        end
        // Logical shift of {C,A,Q}: C refills with zero.
        a_nxt = sum[n:1];
        q_nxt = {sum[0], q[n-1:1]};
        c_nxt = 1'b0;
`endif
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = IDLE;
          ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      m     <= '0;
      q     <= '0;
      a     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      ready <= 1'b1;
`ifdef BOOTH_EN
      qm1   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      m     <= m_nxt;
      q     <= q_nxt;
      a     <= a_nxt;
      c     <= c_nxt;
      cnt   <= cnt_nxt;
      ready <= ready_nxt;
`ifdef BOOTH_EN
      qm1   <= qm1_nxt;
`endif
    end
  end

  assign AQ = {a, q};

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier: one n=4 and one n=8 instance on a
// shared clock and reset. Expected products are hand-computed for the build
// selected by BOOTH_EN.
module tb_seq_multiplier;

`ifdef BOOTH_EN
  localparam logic [7:0]  EXP_E_6   = 8'hF4;   // -2 * 6 = -12
  localparam logic [15:0] EXP_FF_FF = 16'h0001; // -1 * -1
`else
  localparam logic [7:0]  EXP_E_6   = 8'h54;   // 14 * 6 = 84
  localparam logic [15:0] EXP_FF_FF = 16'hFE01; // 255 * 255
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start4 = 1'b0, load4 = 1'b0;
  logic [1:0]  func4 = 2'b00;
  logic [3:0]  din4 = '0;
  logic        ready4;
  logic [7:0]  aq4;
  logic        start8 = 1'b0, load8 = 1'b0;
  logic [1:0]  func8 = 2'b00;
  logic [7:0]  din8 = '0;
  logic        ready8;
  logic [15:0] aq8;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  seq_multiplier #(.n(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .func(func4),
    .load(load4), .data_in(din4), .ready(ready4), .AQ(aq4)
  );

  seq_multiplier #(.n(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .func(func8),
    .load(load8), .data_in(din8), .ready(ready8), .AQ(aq8)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load4_op(input logic [1:0] f, input logic [3:0] d);
    func4 = f; din4 = d; load4 = 1'b1;
    step();
    load4 = 1'b0;
  endtask

  task automatic load8_op(input logic [1:0] f, input logic [7:0] d);
    func8 = f; din8 = d; load8 = 1'b1;
    step();
    load8 = 1'b0;
  endtask

  // Bounded wait for ready4; returns the number of edges waited, -1 on timeout.
  task automatic wait4(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ready4 === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait8(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ready8 === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Start edge, then wait; lat is -1 if ready never dropped or never returned.
  task automatic mul4(output int lat);
    logic dropped;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    dropped = (ready4 === 1'b0);
    wait4(lat);
    if (!dropped) lat = -1;
  endtask

  task automatic mul8(output int lat);
    logic dropped;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    dropped = (ready8 === 1'b0);
    wait8(lat);
    if (!dropped) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (ready4 !== 1'b1) begin failures++; $display("FAIL reset_ready4 got=%b exp=1", ready4); end
    checks++;
    if (aq4 !== 8'h00) begin failures++; $display("FAIL reset_aq4 got=%h exp=00", aq4); end
    checks++;
    if (ready8 !== 1'b1) begin failures++; $display("FAIL reset_ready8 got=%b exp=1", ready8); end
    checks++;
    if (aq8 !== 16'h0000) begin failures++; $display("FAIL reset_aq8 got=%h exp=0000", aq8); end
  endtask

  task automatic test_multiply4();
    int lat;
    load4_op(2'b00, 4'hE);
    load4_op(2'b01, 4'h6);
    mul4(lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL e6_latency got=%0d exp=4", lat); end
    checks++;
    if (aq4 !== EXP_E_6) begin failures++; $display("FAIL e6_product got=%h exp=%h", aq4, EXP_E_6); end
    load4_op(2'b00, 4'h8);
    load4_op(2'b01, 4'h8);
    mul4(lat);
    checks++;
    if (aq4 !== 8'h40) begin failures++; $display("FAIL 88_product got=%h exp=40", aq4); end
  endtask

  task automatic test_corner8();
    int lat;
    load8_op(2'b00, 8'hFF);
    load8_op(2'b01, 8'hFF);
    mul8(lat);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL ffff_latency got=%0d exp=8", lat); end
    checks++;
    if (aq8 !== EXP_FF_FF) begin failures++; $display("FAIL ffff_product got=%h exp=%h", aq8, EXP_FF_FF); end
    load8_op(2'b00, 8'h00);
    load8_op(2'b01, 8'hA5);
    mul8(lat);
    checks++;
    if (aq8 !== 16'h0000) begin failures++; $display("FAIL zero_product got=%h exp=0000", aq8); end
  endtask

  task automatic test_reset_mid();
    int lat;
    load4_op(2'b00, 4'hE);
    load4_op(2'b01, 4'h6);
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (ready4 !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", ready4); end
    checks++;
    if (aq4 !== 8'h00) begin failures++; $display("FAIL midreset_aq got=%h exp=00", aq4); end
    mul4(lat);
    checks++;
    if (aq4 !== 8'h00 || lat !== 4) begin
      failures++; $display("FAIL midreset_next got=%h/%0d exp=00/4", aq4, lat);
    end
  endtask

  task automatic test_start_held();
    int low_cnt;
    load4_op(2'b00, 4'h3);
    load4_op(2'b01, 4'h5);
    low_cnt = 0;
    start4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ready4 === 1'b0) low_cnt++;
    end
    start4 = 1'b0;
    checks++;
    if (low_cnt !== 4) begin failures++; $display("FAIL held_busy_cycles got=%0d exp=4", low_cnt); end
    checks++;
    if (aq4 !== 8'h0F) begin failures++; $display("FAIL held_product got=%h exp=0f", aq4); end
  endtask

  task automatic test_load_busy();
    int lat;
    load4_op(2'b00, 4'h5);
    load4_op(2'b01, 4'h3);
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    func4 = 2'b00; din4 = 4'h3; load4 = 1'b1;
    step();
    step();
    load4 = 1'b0;
    wait4(lat);
    checks++;
    if (aq4 !== 8'h0F || lat < 0) begin failures++; $display("FAIL busyload_product got=%h exp=0f", aq4); end
    load4_op(2'b01, 4'h2);
    mul4(lat);
    checks++;
    if (aq4 !== 8'h0A) begin failures++; $display("FAIL busyload_m_kept got=%h exp=0a", aq4); end
  endtask

  task automatic test_go_load();
    int lat;
    load4_op(2'b00, 4'h5);
    load4_op(2'b01, 4'h3);
    start4 = 1'b1; load4 = 1'b1; func4 = 2'b00; din4 = 4'h2;
    step();
    start4 = 1'b0; load4 = 1'b0;
    checks++;
    if (ready4 !== 1'b0) begin failures++; $display("FAIL goload_started got=%b exp=0", ready4); end
    wait4(lat);
    checks++;
    if (aq4 !== 8'h0F || lat !== 4) begin
      failures++; $display("FAIL goload_product got=%h/%0d exp=0f/4", aq4, lat);
    end
    load4_op(2'b01, 4'h1);
    mul4(lat);
    checks++;
    if (aq4 !== 8'h05) begin failures++; $display("FAIL goload_m_kept got=%h exp=05", aq4); end
  endtask

  task automatic test_back_to_back();
    int lat;
    load4_op(2'b00, 4'h7);
    load4_op(2'b01, 4'h3);
    mul4(lat);
    checks++;
    if (aq4 !== 8'h15) begin failures++; $display("FAIL b2b_first got=%h exp=15", aq4); end
    load4_op(2'b01, 4'h2);
    checks++;
    if (aq4 !== 8'h12 || ready4 !== 1'b1) begin
      failures++; $display("FAIL b2b_hold got=%h/%b exp=12/1", aq4, ready4);
    end
    mul4(lat);
    checks++;
    if (aq4 !== 8'h0E || lat !== 4) begin
      failures++; $display("FAIL b2b_second got=%h/%0d exp=0e/4", aq4, lat);
    end
  endtask

  initial begin
    test_reset();
    test_multiply4();
    test_corner8();
    test_reset_mid();
    test_start_held();
    test_load_busy();
    test_go_load();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
